// File: rtl/fft_input_reorder_pkg.sv
// rtl/fft_input_reorder_pkg.sv - shared constants and bank-state type for the FFT input reorder stage
package fft_input_reorder_pkg;

    localparam int SAMPLE_SIZE        = 16;
    localparam int FFT_POINTS_DEFAULT = 16;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_t;

endpackage

// File: rtl/fft_input_reorder_bitrev.sv
// rtl/fft_input_reorder_bitrev.sv - combinational address bit-reversal (module fft_bitrev)
module fft_bitrev #(
    parameter int ADDR_W = 4
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] rev
);

    always_comb begin
        rev = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            rev[i] = addr[ADDR_W-1-i];
        end
    end

endmodule

// File: rtl/fft_input_reorder.sv
// rtl/fft_input_reorder.sv - ping-pong bit-reversed frame buffer feeding the first radix-2 rank
// Optional FFT_INPUT_SCALE_EN: store each sample arithmetically shifted right by ADDR_W.
module fft_input_reorder
    import fft_input_reorder_pkg::*;
#(
    parameter int FFT_POINTS  = FFT_POINTS_DEFAULT,
    parameter int sample_size = SAMPLE_SIZE
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [sample_size-1:0]             in_sample,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [sample_size-1:0]             out_even_real,
    output logic [sample_size-1:0]             out_odd_real,
    output logic [sample_size-1:0]             out_even_imag,
    output logic [sample_size-1:0]             out_odd_imag,
    output logic [$clog2(FFT_POINTS)-2:0]      out_pair_idx,
    output logic                               out_last
);

    localparam int ADDR_W = $clog2(FFT_POINTS);
    localparam int PAIRS  = FFT_POINTS / 2;

    bank_state_t            bank_state [2];
    logic                   wr_bank;
    logic                   rd_bank;
    logic [ADDR_W-1:0]      wr_cnt;
    logic [ADDR_W-1:0]      wr_addr_rev;
    logic [ADDR_W-2:0]      rd_k;
    logic [sample_size-1:0] mem [2*FFT_POINTS];
    logic [sample_size-1:0] wr_data;

    logic wr_en;
    logic wr_last;
    logic xfer;
    logic xfer_last;
    logic issue_bank;
    logic issue;

    fft_bitrev #(.ADDR_W(ADDR_W)) u_bitrev (
        .addr (wr_cnt),
        .rev  (wr_addr_rev)
    );

`ifdef FFT_INPUT_SCALE_EN
    assign wr_data = sample_size'($signed(in_sample) >>> ADDR_W);
`else
    assign wr_data = in_sample;
`endif

    assign out_even_imag = '0;
    assign out_odd_imag  = '0;

    always_comb begin
        in_ready  = (bank_state[wr_bank] == BANK_EMPTY) || (bank_state[wr_bank] == BANK_FILLING);
        wr_en     = in_valid && in_ready;
        wr_last   = (wr_cnt == ADDR_W'(FFT_POINTS - 1));
        xfer      = out_valid && out_ready;
        xfer_last = xfer && out_last;
        // While the final pair of a frame is on the outputs, the next read comes from the other bank
        issue_bank = (out_valid && out_last) ? ~rd_bank : rd_bank;
        issue      = (!out_valid || out_ready) &&
                     ((bank_state[issue_bank] == BANK_FULL) || (bank_state[issue_bank] == BANK_DRAINING));
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank, wr_addr_rev}] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bank_state[0] <= BANK_EMPTY;
            bank_state[1] <= BANK_EMPTY;
            wr_bank       <= 1'b0;
            rd_bank       <= 1'b0;
            wr_cnt        <= '0;
            rd_k          <= '0;
            out_valid     <= 1'b0;
            out_even_real <= '0;
            out_odd_real  <= '0;
            out_pair_idx  <= '0;
            out_last      <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_cnt                <= wr_cnt + 1'b1;
                bank_state[wr_bank]   <= wr_last ? BANK_FULL : BANK_FILLING;
                if (wr_last) begin
                    wr_bank <= ~wr_bank;
                end
            end

            if (issue) begin
                out_even_real <= mem[{issue_bank, rd_k, 1'b0}];
                out_odd_real  <= mem[{issue_bank, rd_k, 1'b1}];
                out_pair_idx  <= rd_k;
                out_last      <= (rd_k == (ADDR_W-1)'(PAIRS - 1));
                rd_k          <= rd_k + 1'b1;
                if (bank_state[issue_bank] == BANK_FULL) begin
                    bank_state[issue_bank] <= BANK_DRAINING;
                end
            end else if (xfer) begin
                out_last <= 1'b0;
            end

            // The write bank is never FULL/DRAINING, so this never collides with the write update
            if (xfer_last) begin
                bank_state[rd_bank] <= BANK_EMPTY;
                rd_bank             <= ~rd_bank;
            end

            if (issue) begin
                out_valid <= 1'b1;
            end else if (xfer) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fft_input_reorder.sv
// tb/tb_fft_input_reorder.sv - directed self-checking bench for fft_input_reorder (N=16, 16-bit)
module tb_fft_input_reorder;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_sample;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_even_real;
    logic [15:0] out_odd_real;
    logic [15:0] out_even_imag;
    logic [15:0] out_odd_imag;
    logic [2:0]  out_pair_idx;
    logic        out_last;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_even [16];
    int exp_odd  [16];
    int scaled_neg;

    fft_input_reorder #(.FFT_POINTS(16), .sample_size(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sample     (in_sample),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_even_real (out_even_real),
        .out_odd_real  (out_odd_real),
        .out_even_imag (out_even_imag),
        .out_odd_imag  (out_odd_imag),
        .out_pair_idx  (out_pair_idx),
        .out_last      (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic write_sample(input int v);
        int tmp;
        tmp = v;
        check("in_ready_wr", int'(in_ready), 1);
        in_valid  = 1'b1;
        in_sample = tmp[15:0];
        @(posedge clk);
        #1;
    endtask

    task automatic write_ramp(input int base);
        for (int i = 0; i < 16; i++) begin
            write_sample(base + i);
        end
        in_valid = 1'b0;
    endtask

    // Hand-derived bit-reversed pair order for a ramp: (0,8)(4,12)(2,10)(6,14)(1,9)(5,13)(3,11)(7,15)
    task automatic set_ramp(input int base, input int at);
        int ev [8];
        int od [8];
        ev = '{0, 4, 2, 6, 1, 5, 3, 7};
        od = '{8, 12, 10, 14, 9, 13, 11, 15};
        for (int k = 0; k < 8; k++) begin
            exp_even[at+k] = base + ev[k];
            exp_odd[at+k]  = base + od[k];
        end
    endtask

    task automatic collect(input int n, input bit chk_ready);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && !out_valid; c++) begin
            @(posedge clk);
            #1;
        end
        for (int p = 0; p < n; p++) begin
            check("pair_valid", int'(out_valid), 1);
            check("even_real", int'($signed(out_even_real)), exp_even[p]);
            check("odd_real", int'($signed(out_odd_real)), exp_odd[p]);
            check("even_imag", int'(out_even_imag), 0);
            check("odd_imag", int'(out_odd_imag), 0);
            check("pair_idx", int'(out_pair_idx), p % 8);
            check("last", int'(out_last), int'((p % 8) == 7));
            if (chk_ready) begin
                check("in_ready_drain", int'(in_ready), int'(p >= 8));
            end
            @(posedge clk);
            #1;
        end
        check("valid_after_frames", int'(out_valid), 0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sample = '0;
        out_ready = 1'b0;
        do_reset();
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_even", int'(out_even_real), 0);
        check("rst_odd", int'(out_odd_real), 0);
        check("rst_idx", int'(out_pair_idx), 0);
        check("rst_last", int'(out_last), 0);

        // Impulse
        out_ready = 1'b1;
        write_sample(1000);
        for (int i = 1; i < 16; i++) write_sample(0);
        in_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            exp_even[k] = 0;
            exp_odd[k]  = 0;
        end
        exp_even[0] = 1000;
        collect(8, 1'b0);

        // Ramp
        write_ramp(0);
        set_ramp(0, 0);
        collect(8, 1'b0);

        // Backpressure with two frames buffered, then back-to-back drain
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) write_sample(100 + i);
        for (int i = 0; i < 16; i++) write_sample(200 + i);
        in_valid = 1'b0;
        check("full_in_ready", int'(in_ready), 0);
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", int'(out_valid), 1);
            check("bp_even", int'($signed(out_even_real)), 100);
            check("bp_odd", int'($signed(out_odd_real)), 108);
            check("bp_idx", int'(out_pair_idx), 0);
            check("bp_in_ready", int'(in_ready), 0);
            @(posedge clk);
            #1;
        end
        set_ramp(100, 0);
        set_ramp(200, 8);
        collect(16, 1'b1);

        // Reset after 9 writes
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) write_sample(50 + i);
        in_valid = 1'b0;
        do_reset();
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        repeat (10) @(posedge clk);
        #1;
        check("midrst_idle_valid", int'(out_valid), 0);
        write_ramp(300);
        set_ramp(300, 0);
        collect(8, 1'b0);

        // Negative sample, optionally scaled by >>> 4
`ifdef FFT_INPUT_SCALE_EN
        scaled_neg = -100;
`else
        scaled_neg = -1600;
`endif
        write_sample(-1600);
        for (int i = 1; i < 16; i++) write_sample(0);
        in_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            exp_even[k] = 0;
            exp_odd[k]  = 0;
        end
        exp_even[0] = scaled_neg;
        collect(8, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
